fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction decoder/controller. It owns the program counter, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small FIFO. It presents them downstream with a valid/ready handshake, from which the decoder slices opcode, f3 and f7. It flushes and restarts on a redirect (taken branch or jump) from the execute stage.

---
 rtl/core_pkg.sv | 16 +
 rtl/inst_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, reset PC, NOP encoding, word alignment helper.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with flush; head entry read straight from storage registers.
// Storage resets to RESET_VAL so the head shows a defined word while empty.
module inst_fifo #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              CW        = $clog2(DEPTH + 1),
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != {CW{1'b0}});
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
        end else if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response FIFO, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky fault.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = 2 * XLEN;

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_tag_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   w_fifo_count;
    logic [CW-1:0]   w_tag_count;
    logic [CW:0]     w_in_use;
    logic [PW-1:0]   w_payload;
    logic            w_misaligned;
    logic            w_redirect;
    logic            w_grant;
    logic            w_rsp;
    logic            w_accept;
    logic            w_pop;
    logic            w_inst_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misaligned  = |redirect_pc[1:0];
    assign w_redirect_pc = redirect_pc;
`else
    assign w_misaligned  = 1'b0;
    assign w_redirect_pc = word_align(redirect_pc);
`endif

    assign w_redirect   = redirect_valid && (r_state != BOOT);
    assign w_grant      = imem_req && imem_gnt;
    assign w_rsp        = imem_rvalid && (r_outstanding != {CW{1'b0}});
    assign w_accept     = w_rsp && !w_redirect && (r_discard == {CW{1'b0}})
                          && (w_tag_count != {CW{1'b0}});
    assign w_inst_valid = (w_fifo_count != {CW{1'b0}});
    assign w_pop        = w_inst_valid && inst_ready;
    // A pop this cycle frees its slot, which keeps the stream at one word per cycle.
    assign w_in_use     = {1'b0, w_fifo_count} + {1'b0, r_outstanding} - (CW + 1)'(w_pop);

    assign imem_addr  = r_pc;
    assign inst_valid = w_inst_valid;
    assign inst_data  = w_payload[PW-1:XLEN];
    assign inst_pc    = w_payload[XLEN-1:0];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT;
        else        r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     if (w_redirect && w_misaligned) w_state_next = FAULT;
                     else                            w_state_next = RUN;
            FAULT:   if (w_redirect && !w_misaligned) w_state_next = RUN;
                     else                             w_state_next = FAULT;
            default: w_state_next = BOOT;
        endcase
    end

    // FSM outputs
    always_comb begin
        imem_req    = 1'b0;
        fetch_fault = 1'b0;
        if (r_state == RUN) imem_req = !redirect_valid && (w_in_use < (CW + 1)'(DEPTH));
        else                imem_req = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fetch_fault = (r_state == FAULT);
`else
        fetch_fault = 1'b0;
`endif
    end

    // PC and in-flight bookkeeping; discard counts responses owed to flushed requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= {CW{1'b0}};
            r_discard     <= {CW{1'b0}};
        end else begin
            if (w_redirect && !w_misaligned) r_pc <= w_redirect_pc;
            else if (w_grant)                r_pc <= r_pc + 32'd4;
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
            if (w_redirect)
                r_discard <= r_outstanding - CW'(w_rsp);
            else if (w_rsp && (r_discard != {CW{1'b0}}))
                r_discard <= r_discard - CW'(1);
        end
    end

    inst_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (PW),
        .RESET_VAL ({INST_NOP, RESET_PC})
    ) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_redirect),
        .i_push  (w_accept),
        .i_data  ({imem_rdata, w_tag_pc}),
        .i_pop   (w_pop),
        .o_data  (w_payload),
        .o_count (w_fifo_count)
    );

    inst_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_redirect),
        .i_push  (w_grant),
        .i_data  (r_pc),
        .i_pop   (w_accept),
        .o_data  (w_tag_pc),
        .o_count (w_tag_count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus PC/data scoreboard.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int hs_total = 0;

    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        fault_exp;
    logic        resp_en;

    logic        t_req, t_grant, t_valid, t_hs;
    logic [31:0] t_addr, t_data, t_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs, sample outputs, score grants and handshakes.
    task automatic tick(input logic redir, input logic [31:0] rpc, input logic rdy, input logic gnt);
        logic [31:0] e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        imem_gnt       = gnt;
        if (resp_en && mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        t_req = imem_req; t_addr = imem_addr; t_valid = inst_valid;
        t_data = inst_data; t_pc = inst_pc;
        t_grant = imem_req && imem_gnt;
        t_hs    = inst_valid && inst_ready;
        checks++;
        if (fetch_fault !== fault_exp) begin
            errors++; $display("FAIL fault_flag: got %b want %b", fetch_fault, fault_exp);
        end
        if (redir || fault_exp) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++; $display("FAIL req_blocked: got imem_req=%b want 0", imem_req);
            end
        end
        if (t_grant) begin
            checks++;
            if (imem_addr !== exp_pc) begin
                errors++; $display("FAIL grant_addr: got %h want %h", imem_addr, exp_pc);
            end
            mem_q.push_back(imem_addr);
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (t_hs) begin
            hs_total++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL unexpected_inst: got pc %h want none", inst_pc);
            end else begin
                e = exp_q.pop_front();
                if (inst_pc !== e || inst_data !== mem_word(e)) begin
                    errors++;
                    $display("FAIL inst_out: got pc %h data %h want pc %h data %h",
                             inst_pc, inst_data, e, mem_word(e));
                end
            end
        end
        if (redir) begin
            exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) fault_exp = 1'b1;
            else begin fault_exp = 1'b0; exp_pc = rpc; end
`else
            exp_pc = {rpc[31:2], 2'b00};
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        resp_en = 1'b1; fault_exp = 1'b0; exp_pc = 32'h0;
        mem_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %b want 0", imem_req); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (imem_req !== 1'b0)           begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        if (imem_addr !== 32'h0)         begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        if (inst_valid !== 1'b0)         begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        if (inst_data !== 32'h0000_0013) begin errors++; $display("FAIL rst_data: got %h want 00000013", inst_data); end
        if (inst_pc !== 32'h0)           begin errors++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
        if (fetch_fault !== 1'b0)        begin errors++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
        release_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (t_valid !== (i >= 2)) begin
                errors++; $display("FAIL stream_valid[%0d]: got %b want %b", i, t_valid, (i >= 2));
            end
            if (i == 0) begin
                checks++;
                if (t_grant !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", t_grant); end
            end
        end
    endtask

    task automatic test_stall();
        int grants = 0;
        int hs0;
        bit have = 1'b0;
        logic [31:0] held_d, held_pc;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b1);
            if (t_grant) grants++;
            if (have) begin
                checks++;
                if (!t_valid || t_data !== held_d || t_pc !== held_pc) begin
                    errors++; $display("FAIL stall_hold: got %b %h %h want 1 %h %h",
                                       t_valid, t_pc, t_data, held_pc, held_d);
                end
            end else if (t_valid) begin
                have = 1'b1; held_d = t_data; held_pc = t_pc;
            end
        end
        checks += 3;
        if (grants > DEPTH) begin errors++; $display("FAIL stall_grants: got %0d want <= %0d", grants, DEPTH); end
        if (t_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", t_req); end
        if (!have)          begin errors++; $display("FAIL stall_valid: got 0 want 1"); end
        hs0 = hs_total;
        for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (hs_total - hs0 < 8) begin errors++; $display("FAIL stall_drain: got %0d want >= 8", hs_total - hs0); end
    endtask

    task automatic test_redirect_outstanding();
        int grants = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (t_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", t_valid); end
        resp_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1);
            if (t_grant) grants++;
        end
        checks++;
        if (grants != DEPTH) begin errors++; $display("FAIL outstanding_grants: got %0d want %0d", grants, DEPTH); end
        tick(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        resp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1);
            if (i == 0) begin
                checks++;
                if (t_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_low: got %b want 0", t_valid); end
            end
            if (t_hs && !seen) begin
                seen = 1'b1; checks++;
                if (t_pc !== 32'h0000_0100) begin errors++; $display("FAIL redir_first_pc: got %h want 00000100", t_pc); end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL redir_resume: got no instruction want pc 00000100"); end
    endtask

    task automatic test_redirect_same_cycle();
        int hs0;
        bit seen = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
        hs0 = hs_total;
        tick(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        checks += 2;
        if (!(t_valid && imem_rvalid)) begin
            errors++; $display("FAIL same_cycle_setup: got valid %b rvalid %b want 1 1", t_valid, imem_rvalid);
        end
        if (hs_total - hs0 != 1) begin errors++; $display("FAIL same_cycle_hs: got %0d want 1", hs_total - hs0); end
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        checks += 3;
        if (t_valid !== 1'b0)         begin errors++; $display("FAIL n1_valid: got %b want 0", t_valid); end
        if (t_req !== 1'b1)           begin errors++; $display("FAIL n1_req: got %b want 1", t_req); end
        if (t_addr !== 32'h0000_0200) begin errors++; $display("FAIL n1_addr: got %h want 00000200", t_addr); end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1);
            if (t_hs && !seen) begin
                seen = 1'b1; checks++;
                if (t_pc !== 32'h0000_0200) begin errors++; $display("FAIL same_cycle_pc: got %h want 00000200", t_pc); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        logic [31:0] want[3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        tick(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1);
            if (t_grant) addrs.push_back(t_addr);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addrs.size() <= i) begin
                errors++; $display("FAIL wrap_addr[%0d]: got none want %h", i, want[i]);
            end else if (addrs[i] !== want[i]) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addrs[i], want[i]);
            end
        end
    endtask

    task automatic test_misalign();
`ifdef FETCH_MISALIGN_CHECK_EN
        tick(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (t_valid !== 1'b0) begin errors++; $display("FAIL fault_valid: got %b want 0", t_valid); end
        tick(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (t_addr !== 32'h0000_0200) begin errors++; $display("FAIL fault_resume: got %h want 00000200", t_addr); end
        for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
`else
        tick(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (t_addr !== 32'h0000_0100) begin errors++; $display("FAIL align_force: got %h want 00000100", t_addr); end
        for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", inst_valid); end
        if (imem_req !== 1'b0)   begin errors++; $display("FAIL midrst_req: got %b want 0", imem_req); end
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", imem_addr); end
        apply_reset();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1);
            if (t_hs && !seen) begin
                seen = 1'b1; checks++;
                if (t_pc !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h want 0", t_pc); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_wrap();
        test_misalign();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
